// File: rtl/hex_display_ctrl.sv
// N-digit hex display controller for active-low 7-segment digits.
// Provides a registered static per-digit bus plus a time-multiplexed scan bus.
module hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter int unsigned SCAN_DIV   = 50_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [6:0]              seg_scan,
    output logic [NUM_DIGITS-1:0]   dig_sel
);

    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7*NUM_DIGITS-1:0] hex_d;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   sel_d;
    logic                    zero_above;
    logic                    blank;

    // Digit decode with leading-zero and blink blanking, scanned from the MSD down.
    always_comb begin
        hex_d      = '1;
        zero_above = 1'b1;
        blank      = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (value_q[4*k +: 4] == 4'h0);
            blank = ((k != 0) && blank_lz && zero_above)
                  || (blink_en && phase_q && blink_mask[k]);
            hex_d[7*k +: 7] = blank ? 7'h7F : decode(value_q[4*k +: 4]);
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Segment slice and select come from the same next-state index and next hex word.
    always_comb begin
        seg_d = 7'h7F;
        sel_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IW'(k)) begin
                seg_d    = hex_d[7*k +: 7];
                sel_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            hex_out     <= '1;
            seg_scan    <= 7'h7F;
            dig_sel     <= '1;
        end else begin
            if (load) begin
                value_q <= value;
            end
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            hex_out     <= hex_d;
            seg_scan    <= seg_d;
            dig_sel     <= sel_d;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: cycle model plus directed literal checks.
module tb_hex_display_ctrl;

    localparam int N  = 6;
    localparam int BD = 4;
    localparam int SD = 3;

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [23:0]   value = '0;
    logic          blank_lz = 1'b0;
    logic          blink_en = 1'b0;
    logic [5:0]    blink_mask = '0;
    logic [41:0]   hex_out;
    logic [6:0]    seg_scan;
    logic [5:0]    dig_sel;

    int n_cmp = 0;
    int n_bad = 0;

    hex_display_ctrl #(
        .NUM_DIGITS (N),
        .BLINK_DIV  (BD),
        .SCAN_DIV   (SD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .blink_mask (blink_mask),
        .hex_out    (hex_out),
        .seg_scan   (seg_scan),
        .dig_sel    (dig_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: value latched on load, blink phase from the run length of blink_en,
    // scan index from the number of edges since reset.
    logic [23:0] m_val;
    int          m_b, m_e, m_idx;
    logic        m_ph, m_blank;
    logic [41:0] m_hex;
    logic [6:0]  m_seg;
    logic [5:0]  m_sel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = '0;
            m_b   = 0;
            m_e   = 0;
            m_hex = '1;
            m_seg = 7'h7F;
            m_sel = '1;
        end else begin
            m_ph = blink_en && (((m_b / BD) % 2) == 1);
            for (int k = 0; k < N; k++) begin
                m_blank = ((k >= 1) && blank_lz && ((m_val >> (4 * k)) == 24'd0))
                        || (m_ph && blink_mask[k]);
                m_hex[7*k +: 7] = m_blank ? 7'h7F : SEG[m_val[4*k +: 4]];
            end
            if (load) m_val = value;
            m_b   = blink_en ? m_b + 1 : 0;
            m_e   = m_e + 1;
            m_idx = (m_e / SD) % N;
            m_sel = ~(6'd1 << m_idx);
            m_seg = m_hex[7*m_idx +: 7];
        end
    end

    always @(negedge clk) begin
        check("hex_out", {22'd0, hex_out}, {22'd0, m_hex});
        check("seg_scan", {57'd0, seg_scan}, {57'd0, m_seg});
        check("dig_sel", {58'd0, dig_sel}, {58'd0, m_sel});
    end

    task automatic after_release_checks();
        @(negedge clk);
        check("lit_rel_hex", {22'd0, hex_out}, {22'd0, {6{7'h40}}});
        check("lit_rel_sel1", {58'd0, dig_sel}, 64'h3E);
        repeat (2) @(negedge clk);
        check("lit_rel_sel3", {58'd0, dig_sel}, 64'h3D);
    endtask

    task automatic load_value(input logic [23:0] v);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("lit_rst_hex", {22'd0, hex_out}, {22'd0, {42{1'b1}}});
        check("lit_rst_seg", {57'd0, seg_scan}, 64'h7F);
        check("lit_rst_sel", {58'd0, dig_sel}, 64'h3F);
        rst_n = 1'b1;
        after_release_checks();

        blank_lz = 1'b1;
        load_value(24'h0012AF);
        check("lit_lz_12af", {22'd0, hex_out},
              {22'd0, {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E}});
        load_value(24'h000000);
        check("lit_lz_zero", {22'd0, hex_out}, {22'd0, {{5{7'h7F}}, 7'h40}});
        blank_lz = 1'b0;
        @(negedge clk);
        check("lit_nolz_zero", {22'd0, hex_out}, {22'd0, {6{7'h40}}});

        load_value(24'h123456);
        blink_mask = 6'b000001;
        blink_en   = 1'b1;
        repeat (3) @(negedge clk);
        load  = 1'b1;
        value = 24'hABCDEF;
        @(negedge clk);
        load = 1'b0;
        check("lit_toggle_old", {57'd0, hex_out[6:0]}, 64'h02);
        @(negedge clk);
        check("lit_toggle_d0", {57'd0, hex_out[6:0]}, 64'h7F);
        check("lit_toggle_d1", {57'd0, hex_out[13:7]}, 64'h06);
        check("lit_toggle_d5", {57'd0, hex_out[41:35]}, 64'h08);
        repeat (13) @(negedge clk);
        blink_en = 1'b0;
        @(negedge clk);
        check("lit_blink_off", {57'd0, hex_out[6:0]}, 64'h0E);

        blink_mask = 6'b100010;
        blink_en   = 1'b1;
        blank_lz   = 1'b1;
        load_value(24'h00F00D);
        repeat (16) @(negedge clk);
        blink_en = 1'b0;
        repeat (40) @(negedge clk);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("lit_midrst_hex", {22'd0, hex_out}, {22'd0, {42{1'b1}}});
        check("lit_midrst_sel", {58'd0, dig_sel}, 64'h3F);
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        after_release_checks();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
